// File: rtl/video_fetch_arb.sv
// video_fetch_arb
//   Sequences the PPU cart (CHR/nametable) bus. Background tile fetches run on a
//   dot-phase-locked schedule inside the fetch window and always own the bus.
//   Host PPUDATA accesses are slotted into free dots outside the window.
//
// Optional build macro: VIDEO_FETCH_ARB_DUMMY_NT_EN
//   When defined, render lines perform two dummy NT fetch pairs on dots 337..340.
//   Those dots are then closed to host accesses.
//
// Ports
//   I_clock, I_reset        clock, asynchronous active-low reset
//   I_tick                  one-clock dot enable
//   I_hcount, I_vcount      current dot / line
//   I_render_en             background rendering enabled
//   I_vaddr, I_bg_table     loopy v register, background pattern table select
//   I_host_req/_wren/_addr/_data   host access request (level, held until ack)
//   O_host_ack, O_host_data host access done pulse, read data
//   O_cart_addr/_wren/_data cart bus drive
//   I_cart_data             cart read data
//   O_nt_byte, O_at_byte, O_pt_lo, O_pt_hi, O_tile_valid   latched tile bytes + update pulse
module video_fetch_arb #(
    parameter int unsigned P_pre_line  = 261,
    parameter int unsigned P_vis_lines = 240
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_tick,
    input  logic [8:0]  I_hcount,
    input  logic [8:0]  I_vcount,
    input  logic        I_render_en,
    input  logic [14:0] I_vaddr,
    input  logic        I_bg_table,
    input  logic        I_host_req,
    input  logic        I_host_wren,
    input  logic [13:0] I_host_addr,
    input  logic [7:0]  I_host_data,
    output logic        O_host_ack,
    output logic [7:0]  O_host_data,
    output logic [13:0] O_cart_addr,
    output logic        O_cart_wren,
    output logic [7:0]  O_cart_data,
    input  logic [7:0]  I_cart_data,
    output logic [7:0]  O_nt_byte,
    output logic [7:0]  O_at_byte,
    output logic [7:0]  O_pt_lo,
    output logic [7:0]  O_pt_hi,
    output logic        O_tile_valid
);

    localparam logic [8:0] L_PRE_LINE  = 9'(P_pre_line);
    localparam logic [8:0] L_VIS_LINES = 9'(P_vis_lines);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BG     = 2'd1;
    localparam logic [1:0] S_HOST_A = 2'd2;
    localparam logic [1:0] S_HOST_D = 2'd3;

    // Dots that carry a background fetch on a render line.
    function automatic logic f_fetch_dot(input logic [8:0] h);
        return ((h >= 9'd1) && (h <= 9'd256)) || ((h >= 9'd321) && (h <= 9'd336));
    endfunction

`ifdef VIDEO_FETCH_ARB_DUMMY_NT_EN
    function automatic logic f_dummy_dot(input logic [8:0] h);
        return (h >= 9'd337) && (h <= 9'd340);
    endfunction
`endif

    logic [1:0]  r_state;
    logic [13:0] r_cart_addr;
    logic        r_cart_wren;
    logic [7:0]  r_cart_data;
    logic        r_host_ack;
    logic [7:0]  r_host_data;
    logic [7:0]  r_cap_nt;
    logic [7:0]  r_cap_at;
    logic [7:0]  r_cap_lo;
    logic [7:0]  r_nt_byte;
    logic [7:0]  r_at_byte;
    logic [7:0]  r_pt_lo;
    logic [7:0]  r_pt_hi;
    logic        r_tile_valid;
    logic        r_tile_live;

    logic [1:0]  w_nxt_state;
    logic [13:0] w_nxt_cart_addr;
    logic        w_nxt_cart_wren;
    logic [7:0]  w_nxt_cart_data;
    logic        w_nxt_host_ack;
    logic [7:0]  w_nxt_host_data;
    logic [7:0]  w_nxt_cap_nt;
    logic [7:0]  w_nxt_cap_at;
    logic [7:0]  w_nxt_cap_lo;
    logic [7:0]  w_nxt_nt_byte;
    logic [7:0]  w_nxt_at_byte;
    logic [7:0]  w_nxt_pt_lo;
    logic [7:0]  w_nxt_pt_hi;
    logic        w_nxt_tile_valid;
    logic        w_nxt_tile_live;

    logic        w_render_line;
    logic [8:0]  w_hcount_nxt;
    logic        w_win_cur;
    logic        w_win_nxt;
    logic        w_dummy_cur;
    logic        w_blk_cur;
    logic        w_blk_nxt;
    logic [2:0]  w_phase;
    logic [13:0] w_nt_addr;
    logic [13:0] w_at_addr;
    logic [13:0] w_pt_lo_addr;
    logic [13:0] w_pt_hi_addr;

    // Window / eligibility decode for the current and the following dot.
    always_comb begin
        w_render_line = I_render_en & ((I_vcount < L_VIS_LINES) | (I_vcount == L_PRE_LINE));
        w_hcount_nxt  = I_hcount + 9'd1;
        w_win_cur     = w_render_line & f_fetch_dot(I_hcount);
        w_win_nxt     = w_render_line & f_fetch_dot(w_hcount_nxt);
`ifdef VIDEO_FETCH_ARB_DUMMY_NT_EN
        w_dummy_cur   = w_render_line & f_dummy_dot(I_hcount);
        w_blk_cur     = w_win_cur | w_dummy_cur;
        w_blk_nxt     = w_win_nxt | (w_render_line & f_dummy_dot(w_hcount_nxt));
`else
        w_dummy_cur   = 1'b0;
        w_blk_cur     = w_win_cur;
        w_blk_nxt     = w_win_nxt;
`endif
        // Only the low bits of (hcount-1) matter for the phase.
        w_phase       = I_hcount[2:0] - 3'd1;
        w_nt_addr     = {2'b10, I_vaddr[11:0]};
        w_at_addr     = {2'b10, I_vaddr[11:10], 4'b1111, I_vaddr[9:7], I_vaddr[4:2]};
        w_pt_lo_addr  = {1'b0, I_bg_table, r_cap_nt, 1'b0, I_vaddr[14:12]};
        w_pt_hi_addr  = {1'b0, I_bg_table, r_cap_nt, 1'b1, I_vaddr[14:12]};
    end

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_cart_addr  = r_cart_addr;
        w_nxt_cart_wren  = r_cart_wren;
        w_nxt_cart_data  = r_cart_data;
        w_nxt_host_ack   = 1'b0;
        w_nxt_host_data  = r_host_data;
        w_nxt_cap_nt     = r_cap_nt;
        w_nxt_cap_at     = r_cap_at;
        w_nxt_cap_lo     = r_cap_lo;
        w_nxt_nt_byte    = r_nt_byte;
        w_nxt_at_byte    = r_at_byte;
        w_nxt_pt_lo      = r_pt_lo;
        w_nxt_pt_hi      = r_pt_hi;
        w_nxt_tile_valid = 1'b0;
        w_nxt_tile_live  = r_tile_live;

        if (I_tick) begin
            w_nxt_cart_wren = 1'b0;
            if (r_state == S_HOST_A) begin
                // r_cart_wren still holds the direction of the access in flight.
                if (!r_cart_wren) begin
                    w_nxt_host_data = I_cart_data;
                end
                w_nxt_host_ack  = 1'b1;
                w_nxt_tile_live = 1'b0;
                w_nxt_state     = S_HOST_D;
            end else if (w_win_cur) begin
                w_nxt_state = S_BG;
                case (w_phase)
                    3'd0: begin
                        w_nxt_cart_addr = w_nt_addr;
                        w_nxt_tile_live = 1'b1;
                    end
                    3'd1: w_nxt_cap_nt    = I_cart_data;
                    3'd2: w_nxt_cart_addr = w_at_addr;
                    3'd3: w_nxt_cap_at    = I_cart_data;
                    3'd4: w_nxt_cart_addr = w_pt_lo_addr;
                    3'd5: w_nxt_cap_lo    = I_cart_data;
                    3'd6: w_nxt_cart_addr = w_pt_hi_addr;
                    3'd7: begin
                        // A tile interrupted by render_en dropping is never published.
                        if (r_tile_live) begin
                            w_nxt_nt_byte    = r_cap_nt;
                            w_nxt_at_byte    = r_cap_at;
                            w_nxt_pt_lo      = r_cap_lo;
                            w_nxt_pt_hi      = I_cart_data;
                            w_nxt_tile_valid = 1'b1;
                        end
                        w_nxt_tile_live = 1'b0;
                    end
                endcase
            end else begin
                w_nxt_tile_live = 1'b0;
                w_nxt_state     = S_IDLE;
                if (w_dummy_cur) begin
                    // Dummy NT pairs: address only, data is discarded.
                    if (!w_phase[0]) begin
                        w_nxt_cart_addr = w_nt_addr;
                    end
                end else if ((r_state != S_HOST_D) && I_host_req && !w_blk_cur && !w_blk_nxt) begin
                    // Two free dots guarantee the access ends before the window reopens.
                    w_nxt_cart_addr = I_host_addr;
                    w_nxt_cart_wren = I_host_wren;
                    w_nxt_cart_data = I_host_data;
                    w_nxt_state     = S_HOST_A;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_state      <= S_IDLE;
            r_cart_addr  <= 14'd0;
            r_cart_wren  <= 1'b0;
            r_cart_data  <= 8'd0;
            r_host_ack   <= 1'b0;
            r_host_data  <= 8'd0;
            r_cap_nt     <= 8'd0;
            r_cap_at     <= 8'd0;
            r_cap_lo     <= 8'd0;
            r_nt_byte    <= 8'd0;
            r_at_byte    <= 8'd0;
            r_pt_lo      <= 8'd0;
            r_pt_hi      <= 8'd0;
            r_tile_valid <= 1'b0;
            r_tile_live  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cart_addr  <= w_nxt_cart_addr;
            r_cart_wren  <= w_nxt_cart_wren;
            r_cart_data  <= w_nxt_cart_data;
            r_host_ack   <= w_nxt_host_ack;
            r_host_data  <= w_nxt_host_data;
            r_cap_nt     <= w_nxt_cap_nt;
            r_cap_at     <= w_nxt_cap_at;
            r_cap_lo     <= w_nxt_cap_lo;
            r_nt_byte    <= w_nxt_nt_byte;
            r_at_byte    <= w_nxt_at_byte;
            r_pt_lo      <= w_nxt_pt_lo;
            r_pt_hi      <= w_nxt_pt_hi;
            r_tile_valid <= w_nxt_tile_valid;
            r_tile_live  <= w_nxt_tile_live;
        end
    end

    assign O_host_ack   = r_host_ack;
    assign O_host_data  = r_host_data;
    assign O_cart_addr  = r_cart_addr;
    assign O_cart_wren  = r_cart_wren;
    assign O_cart_data  = r_cart_data;
    assign O_nt_byte    = r_nt_byte;
    assign O_at_byte    = r_at_byte;
    assign O_pt_lo      = r_pt_lo;
    assign O_pt_hi      = r_pt_hi;
    assign O_tile_valid = r_tile_valid;

endmodule

// File: tb/tb_video_fetch_arb.sv
// tb_video_fetch_arb
//   Drives whole scan lines dot by dot (one tick every two clocks) with a simple
//   cart ROM model. Expected tiles and host transactions are queued when the line
//   is planned; a monitor pops them whenever O_tile_valid / O_host_ack fires.
`timescale 1ns/1ps
module tb_video_fetch_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [8:0]  hcount = 9'd0;
    logic [8:0]  vcount = 9'd0;
    logic        ren = 1'b0;
    logic [14:0] vaddr = 15'd0;
    logic        bg = 1'b0;
    logic        host_req = 1'b0;
    logic        host_wren = 1'b0;
    logic [13:0] host_addr = 14'd0;
    logic [7:0]  host_wdata = 8'd0;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [13:0] cart_addr;
    logic        cart_wren;
    logic [7:0]  cart_wdata;
    logic [7:0]  cart_rdata;
    logic [7:0]  nt_byte, at_byte, pt_lo, pt_hi;
    logic        tile_valid;

    video_fetch_arb dut (
        .I_clock     (clk),
        .I_reset     (rst_n),
        .I_tick      (tick),
        .I_hcount    (hcount),
        .I_vcount    (vcount),
        .I_render_en (ren),
        .I_vaddr     (vaddr),
        .I_bg_table  (bg),
        .I_host_req  (host_req),
        .I_host_wren (host_wren),
        .I_host_addr (host_addr),
        .I_host_data (host_wdata),
        .O_host_ack  (host_ack),
        .O_host_data (host_rdata),
        .O_cart_addr (cart_addr),
        .O_cart_wren (cart_wren),
        .O_cart_data (cart_wdata),
        .I_cart_data (cart_rdata),
        .O_nt_byte   (nt_byte),
        .O_at_byte   (at_byte),
        .O_pt_lo     (pt_lo),
        .O_pt_hi     (pt_hi),
        .O_tile_valid(tile_valid)
    );

    always #5 clk = ~clk;

    // Cart ROM: address-dependent bytes; 0x2000 reads 0x5A.
    function automatic logic [7:0] cart_f(input logic [13:0] a);
        return 8'h7A ^ a[7:0] ^ {2'b00, a[13:8]};
    endfunction
    assign cart_rdata = cart_f(cart_addr);

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int h_done;
        int a_nt, a_at, a_lo, a_hi;
        int nt, at, lo, hi;
    } tile_t;
    typedef struct {
        int h_ack;
        bit wr;
        int addr;
        int data;
        int rd;
    } host_t;

    tile_t tile_q[$];
    host_t host_q[$];
    int    exp_wren_clks = 0;
    int    wren_clks = 0;

    function automatic bit m_render(input int vc, input bit en);
        return en && (vc < 240 || vc == 261);
    endfunction

    function automatic bit m_fetch_dot(input int h);
        return (h >= 1 && h <= 256) || (h >= 321 && h <= 336);
    endfunction

    function automatic bit m_busy(input int vc, input bit en, input int h);
        bit b = m_fetch_dot(h);
`ifdef VIDEO_FETCH_ARB_DUMMY_NT_EN
        b = b || (h >= 337 && h <= 340);
`endif
        return m_render(vc, en) && b;
    endfunction

    function automatic tile_t m_tile(input int t0, input logic [14:0] v, input bit bgt);
        tile_t e;
        int vi = int'(v);
        e.h_done = t0 + 7;
        e.a_nt = 'h2000 | (vi & 'hFFF);
        e.a_at = 'h23C0 | (((vi >> 10) & 3) << 10) | (((vi >> 7) & 7) << 3) | ((vi >> 2) & 7);
        e.nt   = int'(cart_f(14'(e.a_nt)));
        e.at   = int'(cart_f(14'(e.a_at)));
        e.a_lo = int'(bgt) * 4096 + e.nt * 16 + ((vi >> 12) & 7);
        e.a_hi = e.a_lo + 8;
        e.lo   = int'(cart_f(14'(e.a_lo)));
        e.hi   = int'(cart_f(14'(e.a_hi)));
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [13:0] addr_log [0:340];
    logic        wren_log [0:340];
    logic [7:0]  wdat_log [0:340];

    initial begin
        bit    t;
        int    h;
        tile_t et;
        host_t eh;
        forever begin
            @(posedge clk);
            t = tick;
            h = int'(hcount);
            #1;
            if (cart_wren) wren_clks++;
            if (t) begin
                addr_log[h] = cart_addr;
                wren_log[h] = cart_wren;
                wdat_log[h] = cart_wdata;
            end
            if (tile_valid) begin
                if (tile_q.size() == 0) begin
                    chk("tile_unexpected", 32'(h), 32'hFFFF);
                end else begin
                    et = tile_q.pop_front();
                    chk("tile_dot", t ? 32'(h) : 32'd999, 32'(et.h_done));
                    if (et.h_done >= 7 && et.h_done <= 340) begin
                        chk("addr_nt", 32'(addr_log[et.h_done-7]), 32'(et.a_nt));
                        chk("addr_at", 32'(addr_log[et.h_done-5]), 32'(et.a_at));
                        chk("addr_lo", 32'(addr_log[et.h_done-3]), 32'(et.a_lo));
                        chk("addr_hi", 32'(addr_log[et.h_done-1]), 32'(et.a_hi));
                        chk("fetch_wren", 32'(wren_log[et.h_done-7] | wren_log[et.h_done-1]), 32'd0);
                    end
                    chk("nt_byte", 32'(nt_byte), 32'(et.nt));
                    chk("at_byte", 32'(at_byte), 32'(et.at));
                    chk("pt_lo", 32'(pt_lo), 32'(et.lo));
                    chk("pt_hi", 32'(pt_hi), 32'(et.hi));
                end
            end
            if (host_ack) begin
                if (host_q.size() == 0) begin
                    chk("ack_unexpected", 32'(h), 32'hFFFF);
                end else begin
                    eh = host_q.pop_front();
                    chk("ack_dot", t ? 32'(h) : 32'd999, 32'(eh.h_ack));
                    if (eh.h_ack >= 1 && eh.h_ack <= 340) begin
                        chk("host_bus_addr", 32'(addr_log[eh.h_ack-1]), 32'(eh.addr));
                        chk("host_bus_wren", 32'(wren_log[eh.h_ack-1]), 32'(eh.wr));
                        if (eh.wr) chk("host_bus_data", 32'(wdat_log[eh.h_ack-1]), 32'(eh.data));
                        chk("wren_after_ack", 32'(wren_log[eh.h_ack]), 32'd0);
                    end
                    if (!eh.wr) chk("host_rdata", 32'(host_rdata), 32'(eh.rd));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_line(input int vc, input logic [14:0] v, input bit bgt, input bit en,
                            input int drop_lo, input int drop_hi,
                            input bit hreq, input int hdot, input bit hwr,
                            input logic [13:0] ha, input logic [7:0] hd);
        bit    ren_arr [0:340];
        bit    ok;
        int    s;
        host_t eh;
        for (int h = 0; h <= 340; h++) ren_arr[h] = en && !(h >= drop_lo && h <= drop_hi);
        for (int t0 = 1; t0 <= 329; t0 += 8) begin
            if (t0 <= 249 || t0 >= 321) begin
                ok = 1'b1;
                for (int k = 0; k < 8; k++)
                    ok = ok && m_render(vc, ren_arr[t0+k]) && m_fetch_dot(t0+k);
                if (ok) tile_q.push_back(m_tile(t0, v, bgt));
            end
        end
        if (hreq) begin
            s = hdot;
            while (s < 339 && (m_busy(vc, ren_arr[s], s) || m_busy(vc, ren_arr[s+1], s+1))) s++;
            eh.h_ack = s + 1;
            eh.wr    = hwr;
            eh.addr  = int'(ha);
            eh.data  = int'(hd);
            eh.rd    = int'(cart_f(ha));
            host_q.push_back(eh);
            if (hwr) exp_wren_clks += 2;
        end
        for (int h = 0; h <= 340; h++) begin
            @(negedge clk);
            hcount = 9'(h);
            vcount = 9'(vc);
            ren    = ren_arr[h];
            vaddr  = v;
            bg     = bgt;
            tick   = 1'b1;
            if (hreq && h == hdot) begin
                host_req   = 1'b1;
                host_wren  = hwr;
                host_addr  = ha;
                host_wdata = hd;
            end
            @(negedge clk);
            tick = 1'b0;
            if (host_ack) host_req = 1'b0;
        end
        host_req = 1'b0;
    endtask

    // Reset asserted while a host read sits in its address phase.
    task automatic run_reset();
        host_t eh;
        for (int h = 90; h <= 170; h++) begin
            @(negedge clk);
            hcount = 9'(h);
            vcount = 9'd10;
            ren    = 1'b0;
            tick   = 1'b1;
            if (h == 100 || h == 150) begin
                host_req   = 1'b1;
                host_wren  = 1'b0;
                host_addr  = (h == 100) ? 14'h0456 : 14'h1ABC;
                host_wdata = 8'h00;
            end
            if (h == 150) begin
                eh.h_ack = 151;
                eh.wr    = 1'b0;
                eh.addr  = 'h1ABC;
                eh.data  = 0;
                eh.rd    = int'(cart_f(14'h1ABC));
                host_q.push_back(eh);
            end
            @(negedge clk);
            tick = 1'b0;
            if (h == 100) begin
                chk("rst_pre_addr", 32'(cart_addr), 32'h0456);
                rst_n    = 1'b0;
                host_req = 1'b0;
                #1;
                chk("rst_cart_addr", 32'(cart_addr), 32'd0);
                chk("rst_cart_wren", 32'(cart_wren), 32'd0);
                chk("rst_cart_data", 32'(cart_wdata), 32'd0);
                chk("rst_host_ack", 32'(host_ack), 32'd0);
                chk("rst_host_data", 32'(host_rdata), 32'd0);
                chk("rst_tile_bytes", {nt_byte, at_byte, pt_lo, pt_hi}, 32'd0);
                chk("rst_tile_valid", 32'(tile_valid), 32'd0);
            end
            if (h == 104) rst_n = 1'b1;
            if (host_ack) host_req = 1'b0;
        end
        host_req = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sel, vc, dlo, dhi;
        bit          en, hr;
        logic [14:0] rv;
        repeat (3) @(negedge clk);
        chk("reset_cart_addr", 32'(cart_addr), 32'd0);
        chk("reset_cart_wren", 32'(cart_wren), 32'd0);
        chk("reset_host_ack", 32'(host_ack), 32'd0);
        chk("reset_tile", {nt_byte, at_byte, pt_lo, pt_hi}, 32'd0);
        chk("reset_tile_valid", 32'(tile_valid), 32'd0);
        rst_n = 1'b1;

        run_line(0,   15'h0000, 1'b1, 1'b1, -1, -1, 1'b0, 0,   1'b0, 14'h0,    8'h0);
        run_line(261, 15'h0C5F, 1'b0, 1'b1, -1, -1, 1'b0, 0,   1'b0, 14'h0,    8'h0);
        run_line(241, 15'h1234, 1'b0, 1'b1, -1, -1, 1'b1, 50,  1'b1, 14'h3F00, 8'h21);
        run_line(10,  15'h2A51, 1'b0, 1'b1, -1, -1, 1'b1, 100, 1'b0, 14'h0123, 8'h0);
        run_line(10,  15'h2A51, 1'b0, 1'b0, -1, -1, 1'b1, 100, 1'b0, 14'h2ABC, 8'h0);
        run_line(20,  15'h4B7E, 1'b1, 1'b1, 75, 90, 1'b0, 0,   1'b0, 14'h0,    8'h0);
        run_line(5,   15'h7FFF, 1'b1, 1'b1, -1, -1, 1'b1, 319, 1'b0, 14'h0F0F, 8'h0);
        run_reset();

        for (int n = 0; n < 12; n++) begin
            sel = int'($urandom_range(0, 3));
            vc  = (sel == 1) ? 261 : (sel == 2) ? int'($urandom_range(240, 260)) : int'($urandom_range(0, 239));
            en  = ($urandom_range(0, 3) != 0);
            rv  = 15'($urandom);
            dlo = -1;
            dhi = -1;
            hr  = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                dlo = int'($urandom_range(1, 330));
                dhi = dlo + int'($urandom_range(0, 20));
            end else begin
                hr = ($urandom_range(0, 1) == 1);
            end
            run_line(vc, rv, 1'($urandom_range(0, 1)), en, dlo, dhi, hr,
                     int'($urandom_range(0, 320)), 1'($urandom_range(0, 1)),
                     14'($urandom), 8'($urandom));
        end

        repeat (6) @(negedge clk);
        chk("tiles_outstanding", 32'(tile_q.size()), 32'd0);
        chk("hosts_outstanding", 32'(host_q.size()), 32'd0);
        chk("wren_clocks", 32'(wren_clks), 32'(exp_wren_clks));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
